// File: rtl/serial_tx_if.sv
// Word handshake between a producer and serial_tx.
// in_data/in_valid flow to the transmitter; in_ready returns to the producer.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/serial_tx.sv
// Framed LSB-first serial transmitter: start, data, optional even parity, stop.
// Ports: clk, rst (async high), in_if (word handshake), tx line, busy, done pulse.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       rst,
  serial_tx_if.slave in_if,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST =
    BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    bit_end = (cnt_q == CNT_LAST);

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (in_if.in_valid) begin
          state_d = START;
          sh_d    = in_if.in_data;
          par_d   = ^in_if.in_data;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they
    // leave the flops aligned with the state they describe.
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase

    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  assign in_if.in_ready = rdy_q;
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
